inert_spi_sched: RTL and testbench
==================================

# inert_spi_sched

Sequences and shares the single SPI master that talks to the NEMO inertial sensor. After reset it runs the NEMO configuration writes and raises `setup_done`. It then arbitrates between INT-triggered yaw reads and a host register-access port, granting them round-robin. It sits between `SPI_mnrch` and the inertial integrator and command processor inside `KnightsTour`.

## Interface
Parameters:
- `PWRUP_W`, default 15. Power-up wait is 2^PWRUP_W clocks; benches override it to 4.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `spi_wrt` out 1: one-cycle start pulse to the SPI master.
- `spi_cmd` out 16: SPI word. Held stable from the `spi_wrt` cycle until `spi_done`.
- `spi_done` in 1: one-cycle completion pulse from the SPI master.
- `spi_rd` in 16: SPI read data. Valid in the `spi_done` cycle.
- `INT` in 1: asynchronous NEMO data-ready interrupt.
- `host_req` in 1: level request from the host port; held until `host_gnt`.
- `host_cmd` in 16: host SPI word. Captured in the `host_gnt` cycle.
- `host_gnt` out 1: one-cycle pulse marking acceptance of the host request.
- `host_done` out 1: one-cycle pulse; `host_rd` is valid in this cycle.
- `host_rd` out 8: low byte of the host transaction's read data.
- `yaw` out 16: latest yaw word, {high byte, low byte}.
- `yaw_vld` out 1: one-cycle pulse signalling that `yaw` was updated.
- `setup_done` out 1: configuration complete. Sticky until reset.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **States:** PWRUP, CFG, CFG_WAIT, IDLE, YAWL, YAWL_WAIT, YAWH, YAWH_WAIT, HOST_WAIT.
- **PWRUP:**
  - A PWRUP_W-bit counter runs from 0.
  - On terminal count the FSM goes to CFG with index 0.
  - `spi_done` is ignored in this state.
- **CFG / CFG_WAIT:**
  - Index 0,1,2 issues `16'h0D02`, `16'h1160`, `16'h1440` in that order.
  - Each write is a `spi_wrt` pulse followed by a wait for `spi_done`.
  - After the third `spi_done`, `setup_done` is set and the FSM goes to IDLE.
- **INT handling:**
  - `INT` passes through a 2-flop synchronizer plus one previous-value flop.
  - A rising edge sets `int_pend`.
  - `int_pend` is cleared when YAWL is entered.
  - If a new edge arrives in that same cycle, the set wins.
  - Edges before `setup_done` are still latched.
- **Host requests:** `host_req` is not granted before `setup_done`; it simply stays pending.
- **IDLE arbitration:**
  - Yaw is pending if `int_pend`=1; host is pending if `host_req`=1.
  - With one requester pending, it is served.
  - With both pending, the requester not served last is granted.
  - The `last_was_yaw` flag resets to 0, so yaw wins the first tie.
- **Yaw read:**
  - YAWL issues `16'hA600`; its `spi_rd[7:0]` is stored as the low byte.
  - YAWH issues `16'hA700`; its `spi_rd[7:0]` is the high byte.
  - `yaw` is updated atomically (both bytes at once), with `yaw_vld` pulsed.
  - The FSM then returns to IDLE.
- **Host transaction:**
  - In IDLE, grant means `host_gnt`=1 and `spi_wrt`=1 in the same cycle, with `spi_cmd`=`host_cmd`.
  - In HOST_WAIT, `spi_done` produces `host_rd`=`spi_rd[7:0]` and a `host_done` pulse.
- **Reset:**
  - Reset at any point returns to PWRUP and restarts configuration.
  - Reset values: `spi_wrt` 0, `spi_cmd` 0, `host_gnt` 0, `host_done` 0, `host_rd` 0, `yaw` 0, `yaw_vld` 0, `setup_done` 0, `busy` 1.
  - `int_pend`, the synchronizer flops and `last_was_yaw` reset to 0.

## Timing
- All outputs are registered.
- **`spi_wrt`:** high exactly one cycle per transaction. It is asserted on the edge that leaves IDLE/CFG, or on the YAWL→YAWH transition edge.
- **`spi_cmd`:** changes only on `spi_wrt` edges.
- **INT latency:** with `INT` high setup before edge E1 and the FSM in IDLE, `int_pend`=1 after E3 and `spi_wrt`=1 after E4.
- **Between SPI transfers:** from `spi_done` of the YAWL transfer, the next `spi_wrt` follows 1 cycle later.
- **Yaw completion:** from the YAWH `spi_done`, `yaw_vld`=1 the next cycle and the FSM is in IDLE that same cycle.
- **Host completion:** `host_done` comes 1 cycle after `spi_done`.
- **Turnaround:** the earliest next grant is 1 cycle after `yaw_vld` or `host_done`.
- **Configuration:** `setup_done` rises 1 cycle after the third CFG `spi_done`.
- **Repeated edges:** multiple INT edges during one yaw read collapse into a single pending read.
- **Edge during CFG:** one INT edge during CFG gives exactly one yaw read after `setup_done`.

## Test plan
- **Configuration order:** PWRUP_W=4, rst pulse, `spi_done` returned 10 cycles after each `spi_wrt` → `spi_cmd` sequence 0D02, 1160, 1440; `setup_done` rises 1 cycle after the third `spi_done`; `busy`=0.
- **Yaw read:** `INT` edge in IDLE → `spi_wrt` 4 cycles later with A600. Return `spi_rd`=16'h0034, then A700 with `spi_rd`=16'h0012 → `yaw`=16'h1234 with a single `yaw_vld` pulse.
- **Tie arbitration:** `host_req` with `host_cmd`=16'h8F00 asserted in the same cycle `int_pend` sets → yaw served first. Host is granted in the cycle after `yaw_vld`; `host_done` with `host_rd`=8'h6A when `spi_rd`=16'h006A.
- **Early host request:** `host_req` asserted during PWRUP → no `host_gnt` until after `setup_done`. The first IDLE cycle grants host, since no INT is pending.
- **INT storm:** 3 `INT` edges while in YAWH_WAIT → exactly one further yaw read follows.
- **Reset mid-operation:** `rst` asserted during HOST_WAIT → all outputs return to reset values next cycle, a late `spi_done` is ignored, and the configuration sequence reruns from 0D02.

Source files
------------

// File: rtl/inert_spi_sched_if.sv
// Bundle of SPI-master, INT and host-port signals around the NEMO SPI scheduler.
// master = scheduler side, slave = SPI master / sensor / host side.
interface inert_spi_sched_if;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rd;
  logic        INT;
  logic        host_req;
  logic [15:0] host_cmd;
  logic        host_gnt;
  logic        host_done;
  logic [7:0]  host_rd;
  logic [15:0] yaw;
  logic        yaw_vld;
  logic        setup_done;
  logic        busy;

  modport master (
    output spi_wrt, spi_cmd, host_gnt, host_done, host_rd, yaw, yaw_vld, setup_done, busy,
    input  spi_done, spi_rd, INT, host_req, host_cmd
  );

  modport slave (
    input  spi_wrt, spi_cmd, host_gnt, host_done, host_rd, yaw, yaw_vld, setup_done, busy,
    output spi_done, spi_rd, INT, host_req, host_cmd
  );
endinterface

// File: rtl/inert_spi_sched.sv
// Shares one SPI master between NEMO power-up configuration, INT-driven yaw reads
// and a host register-access port (round-robin once configuration is done).
module inert_spi_sched #(
  parameter int PWRUP_W = 15
) (
  input logic             clk,
  input logic             rst,
  inert_spi_sched_if.master bus
);

  localparam logic [3:0] PWRUP     = 4'd0;
  localparam logic [3:0] CFG       = 4'd1;
  localparam logic [3:0] CFG_WAIT  = 4'd2;
  localparam logic [3:0] IDLE      = 4'd3;
  localparam logic [3:0] YAWL      = 4'd4;
  localparam logic [3:0] YAWL_WAIT = 4'd5;
  localparam logic [3:0] YAWH      = 4'd6;
  localparam logic [3:0] YAWH_WAIT = 4'd7;
  localparam logic [3:0] HOST_WAIT = 4'd8;

  localparam logic [15:0] CMD_YAWL = 16'hA600;
  localparam logic [15:0] CMD_YAWH = 16'hA700;

  logic [3:0]         state;
  logic [3:0]         state_nxt;
  logic [PWRUP_W-1:0] pwr_cnt;
  logic [1:0]         cfg_idx;
  logic               int_p0;
  logic               int_p1;
  logic               int_p2;
  logic               int_rise;
  logic               int_pend;
  logic               last_was_yaw;
  logic               yaw_go;
  logic               host_go;
  logic [7:0]         yaw_lo;

  function automatic logic [15:0] cfg_word(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_word = 16'h0D02;
      2'd1:    cfg_word = 16'h1160;
      default: cfg_word = 16'h1440;
    endcase
  endfunction

  assign int_rise = int_p1 & ~int_p2;

  // Round-robin: on a tie, whoever was not served last wins.
  always_comb begin
    state_nxt = state;
    yaw_go    = 1'b0;
    host_go   = 1'b0;
    case (state)
      PWRUP:     if (&pwr_cnt) state_nxt = CFG;
      CFG:       state_nxt = CFG_WAIT;
      CFG_WAIT:  if (bus.spi_done) state_nxt = (cfg_idx == 2'd2) ? IDLE : CFG;
      IDLE: begin
        if (int_pend && (!bus.host_req || !last_was_yaw)) begin
          yaw_go    = 1'b1;
          state_nxt = YAWL;
        end else if (bus.host_req) begin
          host_go   = 1'b1;
          state_nxt = HOST_WAIT;
        end
      end
      YAWL:      state_nxt = YAWL_WAIT;
      YAWL_WAIT: if (bus.spi_done) state_nxt = YAWH;
      YAWH:      state_nxt = YAWH_WAIT;
      YAWH_WAIT: if (bus.spi_done) state_nxt = IDLE;
      HOST_WAIT: if (bus.spi_done) state_nxt = IDLE;
      default:   state_nxt = PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= PWRUP;
      pwr_cnt        <= '0;
      cfg_idx        <= 2'd0;
      int_p0         <= 1'b0;
      int_p1         <= 1'b0;
      int_p2         <= 1'b0;
      int_pend       <= 1'b0;
      last_was_yaw   <= 1'b0;
      yaw_lo         <= 8'h00;
      bus.spi_wrt    <= 1'b0;
      bus.spi_cmd    <= 16'h0000;
      bus.host_gnt   <= 1'b0;
      bus.host_done  <= 1'b0;
      bus.host_rd    <= 8'h00;
      bus.yaw        <= 16'h0000;
      bus.yaw_vld    <= 1'b0;
      bus.setup_done <= 1'b0;
      bus.busy       <= 1'b1;
    end else begin
      state         <= state_nxt;
      bus.busy      <= (state_nxt != IDLE);
      bus.spi_wrt   <= 1'b0;
      bus.host_gnt  <= 1'b0;
      bus.host_done <= 1'b0;
      bus.yaw_vld   <= 1'b0;

      // INT synchronizer (p0,p1) and edge-history flop (p2)
      int_p0 <= bus.INT;
      int_p1 <= int_p0;
      int_p2 <= int_p1;
      if (int_rise)    int_pend <= 1'b1;
      else if (yaw_go) int_pend <= 1'b0;

      case (state)
        PWRUP: pwr_cnt <= pwr_cnt + 1'b1;
        CFG: begin
          bus.spi_wrt <= 1'b1;
          bus.spi_cmd <= cfg_word(cfg_idx);
        end
        CFG_WAIT: begin
          if (bus.spi_done) begin
            if (cfg_idx == 2'd2) bus.setup_done <= 1'b1;
            else                 cfg_idx <= cfg_idx + 2'd1;
          end
        end
        IDLE: begin
          if (yaw_go) begin
            bus.spi_wrt  <= 1'b1;
            bus.spi_cmd  <= CMD_YAWL;
            last_was_yaw <= 1'b1;
          end else if (host_go) begin
            bus.spi_wrt  <= 1'b1;
            bus.host_gnt <= 1'b1;
            bus.spi_cmd  <= bus.host_cmd;
            last_was_yaw <= 1'b0;
          end
        end
        YAWL_WAIT: begin
          if (bus.spi_done) begin
            yaw_lo      <= bus.spi_rd[7:0];
            bus.spi_wrt <= 1'b1;
            bus.spi_cmd <= CMD_YAWH;
          end
        end
        YAWH_WAIT: begin
          if (bus.spi_done) begin
            bus.yaw     <= {bus.spi_rd[7:0], yaw_lo};
            bus.yaw_vld <= 1'b1;
          end
        end
        HOST_WAIT: begin
          if (bus.spi_done) begin
            bus.host_rd   <= bus.spi_rd[7:0];
            bus.host_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inert_spi_sched.sv
// Randomized bench for inert_spi_sched: SPI-slave responder, random INT/host traffic,
// and a transaction-level reference model of configuration, arbitration and reads.
module tb_inert_spi_sched;

  logic clk;
  logic rst;
  inert_spi_sched_if bus();

  inert_spi_sched #(.PWRUP_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 8;
  int done_at = -1;
  bit int_drv [0:16383];
  bit int_en  = 0;
  bit host_en = 0;
  bit h_active = 0;

  logic [15:0] cfg_tbl [0:2];

  // Reference model state: phase 0 idle, 1 yaw low, 2 yaw high, 3 host, 4 configuring
  int          m_phase;
  int          m_cfg_idx;
  bit          m_cfg_inflight;
  bit          m_setup;
  bit          m_pend;
  bit          m_last_yaw;
  bit          m_yaw_dec_prev;
  logic [7:0]  m_lo;

  bit          exp_wrt, exp_gnt, exp_hdone, exp_yvld, exp_busy, exp_setup, exp_cfg, exp_rstchk;
  logic [15:0] exp_cmd;
  logic [7:0]  exp_hrd;
  logic [15:0] exp_yaw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = 4; m_cfg_idx = 0; m_cfg_inflight = 0; m_setup = 0;
    m_pend = 0; m_last_yaw = 0; m_yaw_dec_prev = 0; m_lo = 8'h00;
    exp_wrt = 0; exp_gnt = 0; exp_hdone = 0; exp_yvld = 0;
    exp_busy = 1; exp_setup = 0; exp_cfg = 1; exp_rstchk = 1;
    exp_cmd = 16'h0000; exp_hrd = 8'h00; exp_yaw = 16'h0000;
  endtask

  task automatic compare();
    if (exp_rstchk) begin
      chk("rst_spi_cmd", 32'(bus.spi_cmd), 32'h0);
      chk("rst_host_rd", 32'(bus.host_rd), 32'h0);
      chk("rst_yaw", 32'(bus.yaw), 32'h0);
      exp_rstchk = 0;
    end
    if (exp_cfg) begin
      if (bus.spi_wrt) chk("cfg_cmd", 32'(bus.spi_cmd), 32'(cfg_tbl[m_cfg_idx]));
    end else begin
      if (bus.spi_wrt || exp_wrt) chk("spi_wrt", 32'(bus.spi_wrt), 32'(exp_wrt));
      if (bus.spi_wrt && exp_wrt) chk("spi_cmd", 32'(bus.spi_cmd), 32'(exp_cmd));
    end
    if (bus.host_gnt || exp_gnt) chk("host_gnt", 32'(bus.host_gnt), 32'(exp_gnt));
    if (bus.host_done || exp_hdone) chk("host_done", 32'(bus.host_done), 32'(exp_hdone));
    if (bus.host_done && exp_hdone) chk("host_rd", 32'(bus.host_rd), 32'(exp_hrd));
    if (bus.yaw_vld || exp_yvld) chk("yaw_vld", 32'(bus.yaw_vld), 32'(exp_yvld));
    if (bus.yaw_vld && exp_yvld) chk("yaw", 32'(bus.yaw), 32'(exp_yaw));
    chk("setup_done", 32'(bus.setup_done), 32'(exp_setup));
    chk("busy", 32'(bus.busy), 32'(exp_busy));
  endtask

  task automatic model(input bit do_rst, input bit done_now, input logic [15:0] rd_now);
    bit rise;
    if (do_rst) begin
      model_reset();
      return;
    end
    exp_wrt = 0; exp_gnt = 0; exp_hdone = 0; exp_yvld = 0;
    // INT edge becomes a pending request three cycles after it is driven
    rise = int_drv[cyc-3] && !int_drv[cyc-4];
    if (rise)                m_pend = 1;
    else if (m_yaw_dec_prev) m_pend = 0;
    m_yaw_dec_prev = 0;
    case (m_phase)
      4: begin
        if (bus.spi_wrt) m_cfg_inflight = 1;
        if (done_now && m_cfg_inflight) begin
          m_cfg_inflight = 0;
          m_cfg_idx++;
          if (m_cfg_idx == 3) begin
            m_cfg_idx = 2;
            m_phase = 0;
            m_setup = 1;
          end
        end
      end
      0: begin
        if (m_pend && (!bus.host_req || !m_last_yaw)) begin
          exp_wrt = 1; exp_cmd = 16'hA600; m_phase = 1;
          m_last_yaw = 1; m_yaw_dec_prev = 1;
        end else if (bus.host_req) begin
          exp_wrt = 1; exp_gnt = 1; exp_cmd = bus.host_cmd; m_phase = 3;
          m_last_yaw = 0;
        end
      end
      1: if (done_now) begin
        m_lo = rd_now[7:0]; exp_wrt = 1; exp_cmd = 16'hA700; m_phase = 2;
      end
      2: if (done_now) begin
        exp_yvld = 1; exp_yaw = {rd_now[7:0], m_lo}; m_phase = 0;
      end
      3: if (done_now) begin
        exp_hdone = 1; exp_hrd = rd_now[7:0]; m_phase = 0;
      end
      default: ;
    endcase
    exp_busy  = (m_phase != 0);
    exp_setup = m_setup;
    exp_cfg   = (m_phase == 4);
  endtask

  task automatic step(input bit do_rst);
    bit          done_now;
    bit          v;
    logic [15:0] rd_now;
    @(posedge clk); #1;
    cyc++;
    compare();
    rst = do_rst;
    // SPI slave responder
    done_now = (cyc == done_at);
    rd_now = 16'($urandom);
    bus.spi_done = done_now;
    bus.spi_rd   = rd_now;
    if (bus.spi_wrt) done_at = cyc + int'($urandom_range(2, 12));
    // INT source
    if (int_en) v = int_drv[cyc-1] ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 11) == 0);
    else        v = 1'b0;
    int_drv[cyc] = v;
    bus.INT = v;
    // Host port
    if (do_rst) begin
      bus.host_req = 1'b0;
      h_active = 0;
    end else begin
      if (bus.host_gnt)  bus.host_req = 1'b0;
      if (bus.host_done) h_active = 0;
      if (host_en && !h_active && $urandom_range(0, 9) == 0) begin
        bus.host_req = 1'b1;
        bus.host_cmd = 16'($urandom);
        h_active = 1;
      end
    end
    model(do_rst, done_now, rd_now);
  endtask

  initial begin
    cfg_tbl[0] = 16'h0D02; cfg_tbl[1] = 16'h1160; cfg_tbl[2] = 16'h1440;
    rst = 1'b1;
    bus.spi_done = 1'b0; bus.spi_rd = 16'h0000; bus.INT = 1'b0;
    bus.host_req = 1'b0; bus.host_cmd = 16'h0000;
    repeat (2) @(posedge clk);
    model_reset();

    // Host request raised during power-up, INT traffic allowed during configuration
    repeat (3) step(0);
    bus.host_req = 1'b1; bus.host_cmd = 16'h8F00; h_active = 1;
    int_en = 1;
    for (int i = 0; i < 300 && !bus.setup_done; i++) step(0);
    chk("setup_timeout", 32'(bus.setup_done), 32'h1);
    host_en = 1;
    repeat (1500) step(0);

    // Reset while a host transaction is in flight
    int_en = 0;
    repeat (6) step(0);
    for (int i = 0; i < 400 && !bus.host_gnt; i++) step(0);
    chk("gnt_timeout", 32'(bus.host_gnt), 32'h1);
    host_en = 0;
    repeat (2) step(0);
    step(1);
    step(0);
    int_en = 1; host_en = 1;
    repeat (1500) step(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
